isp_2dnr_cfg: RTL

ISP_2DNR_CFG -- requirements
Module: isp_2dnr_cfg

---
 rtl/isp_2dnr_pkg.sv | 25 ++
 rtl/isp_2dnr_cfg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/isp_2dnr_pkg.sv
// Shared definitions for the 2DNR configuration block: the register address
// map, the table sizes and the controller state encoding.
package isp_2dnr_pkg;

  // Word address map of the shadow register file
  localparam logic [6:0] SPACE_BASE = 7'd0;   // 49 space weights, [i*7+j]
  localparam logic [6:0] CX_BASE    = 7'd49;  // 9 colour-curve x points
  localparam logic [6:0] CY_BASE    = 7'd58;  // 9 colour-curve y points
  localparam logic [6:0] ADDR_LAST  = 7'd66;  // last mapped word

  localparam int N_SPACE = 49;
  localparam int N_CURVE = 9;

  // Index of the last curve_x pair checked, (7, 8)
  localparam logic [2:0] LAST_PAIR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_WAIT_VS = 3'd2,
    ST_APPLY   = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

endpackage

// File: rtl/isp_2dnr_cfg.sv
// 2DNR configuration controller. Software fills a shadow copy of the space
// kernel and colour curve, then commits. The curve x points are checked for
// monotonicity, and a passing set is copied into the active registers in one
// edge at the next frame start, so the filter never sees a mixed set.
module isp_2dnr_cfg
  import isp_2dnr_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int WEIGHT_BITS = 5
) (
  input  logic                             pclk,
  input  logic                             rst_n,
  input  logic                             cfg_wr,
  input  logic [6:0]                       cfg_addr,
  input  logic [BITS-1:0]                  cfg_wdata,
  output logic [BITS-1:0]                  cfg_rdata,
  input  logic                             cfg_commit,
  input  logic                             in_vsync,
  output logic [N_SPACE*WEIGHT_BITS-1:0]   space_kernel,
  output logic [N_CURVE*BITS-1:0]          color_curve_x,
  output logic [N_CURVE*WEIGHT_BITS-1:0]   color_curve_y,
  output logic                             busy,
  output logic                             cfg_done,
  output logic                             cfg_err
);

  localparam int SK_W = N_SPACE * WEIGHT_BITS;
  localparam int CX_W = N_CURVE * BITS;
  localparam int CY_W = N_CURVE * WEIGHT_BITS;

  state_e          state_q, state_d;
  logic [2:0]      k_q, k_d;
  logic            vs_q, vs_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [BITS-1:0] rdata_q, rdata_d;

  logic [SK_W-1:0] sh_sk_q, sh_sk_d, act_sk_q, act_sk_d;
  logic [CX_W-1:0] sh_cx_q, sh_cx_d, act_cx_q, act_cx_d;
  logic [CY_W-1:0] sh_cy_q, sh_cy_d, act_cy_q, act_cy_d;

  logic            vsync_rise_s;
  logic [BITS-1:0] pair_lo_s, pair_hi_s;
  int              sk_idx_s, cx_idx_s, cy_idx_s;

  // Frame-start detect against the registered copy of vsync
  assign vsync_rise_s = in_vsync & ~vs_q;

  // Controller next state, shadow writes, readback mux and active-set load
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    vs_d     = in_vsync;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = {BITS{1'b0}};
    sh_sk_d  = sh_sk_q;
    sh_cx_d  = sh_cx_q;
    sh_cy_d  = sh_cy_q;
    act_sk_d = act_sk_q;
    act_cx_d = act_cx_q;
    act_cy_d = act_cy_q;

    sk_idx_s  = (int'(cfg_addr) - int'(SPACE_BASE)) * WEIGHT_BITS;
    cx_idx_s  = (int'(cfg_addr) - int'(CX_BASE)) * BITS;
    cy_idx_s  = (int'(cfg_addr) - int'(CY_BASE)) * WEIGHT_BITS;
    pair_lo_s = sh_cx_q[int'(k_q) * BITS +: BITS];
    pair_hi_s = sh_cx_q[(int'(k_q) + 1) * BITS +: BITS];

    // Readback is available in every state; unmapped words read as zero
    if (cfg_addr < CX_BASE) begin
      rdata_d = BITS'(sh_sk_q[sk_idx_s +: WEIGHT_BITS]);
    end else if (cfg_addr < CY_BASE) begin
      rdata_d = sh_cx_q[cx_idx_s +: BITS];
    end else if (cfg_addr <= ADDR_LAST) begin
      rdata_d = BITS'(sh_cy_q[cy_idx_s +: WEIGHT_BITS]);
    end else begin
      rdata_d = {BITS{1'b0}};
    end

    case (state_q)
      ST_IDLE: begin
        // The shadow is only writable while no commit is in flight
        if (cfg_wr && (cfg_addr < CX_BASE)) begin
          sh_sk_d[sk_idx_s +: WEIGHT_BITS] = cfg_wdata[WEIGHT_BITS-1:0];
        end else if (cfg_wr && (cfg_addr < CY_BASE)) begin
          sh_cx_d[cx_idx_s +: BITS] = cfg_wdata;
        end else if (cfg_wr && (cfg_addr <= ADDR_LAST)) begin
          sh_cy_d[cy_idx_s +: WEIGHT_BITS] = cfg_wdata[WEIGHT_BITS-1:0];
        end else begin
          sh_sk_d = sh_sk_q;
        end
        if (cfg_commit) begin
          state_d = ST_CHECK;
          k_d     = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        // One adjacent curve_x pair per cycle; a decreasing pair aborts
        if (pair_lo_s > pair_hi_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (k_q == LAST_PAIR) begin
          state_d = ST_WAIT_VS;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      ST_WAIT_VS: begin
        // The whole set is loaded on the edge that enters APPLY
        if (vsync_rise_s) begin
          state_d  = ST_APPLY;
          act_sk_d = sh_sk_q;
          act_cx_d = sh_cx_q;
          act_cy_d = sh_cy_q;
        end else begin
          state_d = ST_WAIT_VS;
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // All state, shadow and active registers; reset restores the uniform filter
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= 3'd0;
      vs_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= {BITS{1'b0}};
      sh_sk_q  <= {SK_W{1'b1}};
      sh_cx_q  <= {CX_W{1'b1}};
      sh_cy_q  <= {CY_W{1'b1}};
      act_sk_q <= {SK_W{1'b1}};
      act_cx_q <= {CX_W{1'b1}};
      act_cy_q <= {CY_W{1'b1}};
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      vs_q     <= vs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      sh_sk_q  <= sh_sk_d;
      sh_cx_q  <= sh_cx_d;
      sh_cy_q  <= sh_cy_d;
      act_sk_q <= act_sk_d;
      act_cx_q <= act_cx_d;
      act_cy_q <= act_cy_d;
    end
  end

  assign space_kernel  = act_sk_q;
  assign color_curve_x = act_cx_q;
  assign color_curve_y = act_cy_q;
  assign busy          = busy_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
  assign cfg_rdata     = rdata_q;

endmodule
